// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
//
// V8 / V32       : register index and data word types.
// t_wr_arb       : arbitration state (NORMAL, FORCE_MEM).
// t_wr_entry     : one memory-return write, {rw, data}.
// WR_ENTRY_W     : packed width of t_wr_entry.
// WR_FIFO_SLOTS  : physical storage slots in the FIFO (largest legal DEPTH).

package regfile_write_arbiter_pkg;

    typedef logic [7:0]  V8;
    typedef logic [31:0] V32;

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_MEM = 1'b1
    } t_wr_arb;

    typedef struct packed {
        V8  rw;
        V32 data;
    } t_wr_entry;

    localparam int WR_ENTRY_W    = $bits(t_wr_entry);
    localparam int WR_FIFO_SLOTS = 4;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// Memory-return FIFO for the register-file write arbiter.
//
// Parameters:
//   DEPTH      : usable entries, 1..4.
// Ports:
//   clock      : rising-edge clock.
//   reset      : synchronous active-high; empties the FIFO (contents discarded).
//   push       : write push_entry at the tail (ignored when full).
//   push_entry : entry to write, packed t_wr_entry.
//   pop        : drop the head entry (ignored when empty).
//   head       : current head entry (valid when !empty).
//   count      : occupancy, 0..DEPTH.
//   full       : count == DEPTH.
//   empty      : count == 0.
//
// A push only becomes visible at head after the edge that writes it, so
// there is no push-to-pop bypass.

module wr_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WR_ENTRY_W-1:0] push_entry,
    input  logic                  pop,
    output logic [WR_ENTRY_W-1:0] head,
    output logic [2:0]            count,
    output logic                  full,
    output logic                  empty
);

    // Storage is sized for the largest legal DEPTH so the 2-bit pointers
    // index it exactly; only slots 0..DEPTH-1 are ever used.
    logic [WR_ENTRY_W-1:0] mem_q [WR_FIFO_SLOTS];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q,  count_d;
    logic                  push_ok;
    logic                  pop_ok;

    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);

    // Pointers wrap straight from DEPTH-1 back to 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == 3'd0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 3'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data slots need no reset: occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and
// memory returns.
//
// Writeback writes normally win; memory returns queue in a small FIFO and
// take the port when writeback is idle, or when writeback has won
// STARVE_LIMIT consecutive grants while the FIFO was non-empty.
//
// Parameters:
//   DEPTH           : memory-return FIFO entries, 1..4.
//   STARVE_LIMIT    : max consecutive wb grants while the FIFO is non-empty (>= 1).
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset.
//   wb_write_enable : writeback write request; wb_rw / wb_data its payload.
//   wb_finished     : writeback stage holds FINISHED.
//   wb_stall        : wb request present but not taken this cycle.
//   mem_valid       : memory-return request; mem_rw / mem_data its payload.
//   mem_ready       : FIFO accepts an entry this cycle (independent of mem_valid).
//   rf_write_enable : registered register-file write strobe.
//   rf_rw, rf_data  : registered write address / data (hold when no write).
//   pending_count   : FIFO occupancy.
//   drained         : finished and no write queued or in flight.
//   dbg_arb_state_o : current arbitration state (t_wr_arb encoding).
//
// Handshake: a memory entry transfers on an edge where mem_valid && mem_ready;
// the requester holds mem_valid and its payload stable until then.
// The writeback write transfers on any edge where wb_write_enable && !wb_stall.

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_write_enable,
    input  logic [7:0]  wb_rw,
    input  logic [31:0] wb_data,
    input  logic        wb_finished,
    output logic        wb_stall,
    input  logic        mem_valid,
    input  logic [7:0]  mem_rw,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_write_enable,
    output logic [7:0]  rf_rw,
    output logic [31:0] rf_data,
    output logic [2:0]  pending_count,
    output logic        drained,
    output logic        dbg_arb_state_o
);

    localparam int              SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT     = SW'(STARVE_LIMIT);

    t_wr_arb         state_q,   state_d;
    logic [SW-1:0]   starve_q,  starve_d;
    logic            rf_we_q,   rf_we_d;
    V8               rf_rw_q,   rf_rw_d;
    V32              rf_data_q, rf_data_d;

    logic                  grant_wb;
    logic                  grant_mem;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2:0]            fifo_count;
    logic [WR_ENTRY_W-1:0] fifo_head;
    t_wr_entry             head_entry;
    t_wr_entry             push_entry;

    assign push_entry = '{rw: mem_rw, data: mem_data};
    assign head_entry = t_wr_entry'(fifo_head);

    // mem_ready comes only from registered occupancy; it is forced high in
    // reset, where any push is dropped by the FIFO's own reset anyway.
    assign mem_ready = reset || !fifo_full;
    assign fifo_push = mem_valid && mem_ready && !reset;

    wr_fifo #(
        .DEPTH(DEPTH)
    ) u_wr_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_entry(push_entry),
        .pop       (grant_mem),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbitration: next state, grants and register-file write.
    // FORCE_MEM is held exactly when starve_q has reached LIMIT.
    always_comb begin
        grant_wb  = 1'b0;
        grant_mem = 1'b0;
        starve_d  = starve_q;
        state_d   = state_q;
        rf_we_d   = 1'b0;
        rf_rw_d   = rf_rw_q;
        rf_data_d = rf_data_q;

        if (!reset) begin
            if (!fifo_empty && (!wb_write_enable || state_q == FORCE_MEM)) begin
                grant_mem = 1'b1;
            end else if (wb_write_enable) begin
                grant_wb = 1'b1;
            end
        end

        // The starvation count only measures wb wins against a waiting entry.
        if (fifo_empty || grant_mem) begin
            starve_d = '0;
        end else if (grant_wb && starve_q != LIMIT) begin
            starve_d = starve_q + SW'(1);
        end
        state_d = (starve_d == LIMIT) ? FORCE_MEM : NORMAL;

        if (grant_mem) begin
            rf_we_d   = 1'b1;
            rf_rw_d   = head_entry.rw;
            rf_data_d = head_entry.data;
        end else if (grant_wb) begin
            rf_we_d   = 1'b1;
            rf_rw_d   = wb_rw;
            rf_data_d = wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= NORMAL;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_rw_q   <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_rw_q   <= rf_rw_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign wb_stall        = wb_write_enable && grant_mem;
    assign rf_write_enable = rf_we_q;
    assign rf_rw           = rf_rw_q;
    assign rf_data         = rf_data_q;
    assign pending_count   = fifo_count;
    assign drained         = wb_finished && (reset || (fifo_empty && !rf_we_q));
    assign dbg_arb_state_o = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        wb_write_enable;
    logic [7:0]  wb_rw;
    logic [31:0] wb_data;
    logic        wb_finished;
    logic        wb_stall;
    logic        mem_valid;
    logic [7:0]  mem_rw;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_write_enable;
    logic [7:0]  rf_rw;
    logic [31:0] rf_data;
    logic [2:0]  pending_count;
    logic        drained;
    logic        dbg_arb_state_o;

    regfile_write_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wb_write_enable(wb_write_enable),
        .wb_rw          (wb_rw),
        .wb_data        (wb_data),
        .wb_finished    (wb_finished),
        .wb_stall       (wb_stall),
        .mem_valid      (mem_valid),
        .mem_rw         (mem_rw),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .rf_write_enable(rf_write_enable),
        .rf_rw          (rf_rw),
        .rf_data        (rf_data),
        .pending_count  (pending_count),
        .drained        (drained),
        .dbg_arb_state_o(dbg_arb_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks   = 0;
    int n_failures = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [39:0] exp_q[$];   // expected rf writes, in order
    logic [39:0] mq[$];      // model of the memory-return FIFO
    int          starve;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model, tick, then check registered outputs.
    task automatic cycle(input logic rst, input logic we, input logic [7:0] wrw,
                         input logic [31:0] wdat, input logic fin, input logic mv,
                         input logic [7:0] mrw, input logic [31:0] mdat,
                         output logic accepted);
        logic exp_ready, exp_stall, g_mem, g_wb, was_empty;
        logic [39:0] got;
        reset           = rst;
        wb_write_enable = we;
        wb_rw           = wrw;
        wb_data         = wdat;
        wb_finished     = fin;
        mem_valid       = mv;
        mem_rw          = mrw;
        mem_data        = mdat;
        #1;
        exp_ready = rst || (mq.size() < DEPTH);
        g_mem = 1'b0;
        g_wb  = 1'b0;
        if (!rst) begin
            if (mq.size() != 0 && (!we || starve == STARVE_LIMIT)) g_mem = 1'b1;
            else if (we) g_wb = 1'b1;
        end
        exp_stall = g_mem && we;
        check_eq("mem_ready", 64'(mem_ready), 64'(exp_ready));
        check_eq("wb_stall", 64'(wb_stall), 64'(exp_stall));
        accepted  = !rst && mv && exp_ready;
        was_empty = (mq.size() == 0);
        if (g_mem) exp_q.push_back(mq.pop_front());
        else if (g_wb) exp_q.push_back({wrw, wdat});
        if (rst) begin
            mq.delete();
            starve = 0;
        end else begin
            if (accepted) mq.push_back({mrw, mdat});
            if (was_empty || g_mem) starve = 0;
            else if (g_wb && starve < STARVE_LIMIT) starve++;
        end
        @(posedge clock);
        #1;
        check_eq("rf_write_enable", 64'(rf_write_enable), 64'(g_mem || g_wb));
        if (rf_write_enable) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'({rf_rw, rf_data}), 64'hFFFF_FFFF_FFFF);
            end else begin
                got = {rf_rw, rf_data};
                check_eq("rf_rw_data", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        if (rst) begin
            check_eq("reset_rf_rw", 64'(rf_rw), 64'd0);
            check_eq("reset_rf_data", 64'(rf_data), 64'd0);
        end
        check_eq("pending_count", 64'(pending_count), 64'(mq.size()));
        check_eq("drained", 64'(drained), 64'(fin && mq.size() == 0 && !(g_mem || g_wb)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        acc;
        logic        hold_v;
        logic [7:0]  hold_rw, r_rw;
        logic [31:0] hold_d, r_d;
        logic        r_we, r_fin;
        int          k, budget;
        logic [7:0]  e_rw[3];
        logic [31:0] e_d[3];

        starve = 0;
        reset = 1'b1; wb_write_enable = 1'b0; wb_rw = '0; wb_data = '0;
        wb_finished = 1'b0; mem_valid = 1'b0; mem_rw = '0; mem_data = '0;

        // Reset state, with wb_finished high so drained must follow it.
        cycle(1, 0, 0, 0, 1, 0, 0, 0, acc);
        cycle(1, 1, 8'h55, 32'h5, 1, 1, 8'h66, 32'h6, acc);
        check_eq("reset_pending", 64'(pending_count), 64'd0);
        check_eq("reset_state", 64'(dbg_arb_state_o), 64'd0);

        // wb only: rw=3, data=0x11.
        cycle(0, 1, 8'd3, 32'h11, 0, 0, 0, 0, acc);
        check_eq("wb_only_we", 64'(rf_write_enable), 64'd1);
        check_eq("wb_only_rw", 64'(rf_rw), 64'd3);
        check_eq("wb_only_data", 64'(rf_data), 64'h11);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        check_eq("hold_rw", 64'(rf_rw), 64'd3);

        // mem only: accepted at edge t, no write right after t.
        cycle(0, 0, 0, 0, 0, 1, 8'd7, 32'hDEADBEEF, acc);
        check_eq("mem_accept", 64'(acc), 64'd1);
        check_eq("mem_no_bypass", 64'(rf_write_enable), 64'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        check_eq("mem_write_data", 64'(rf_data), 64'hDEADBEEF);
        check_eq("mem_pending0", 64'(pending_count), 64'd0);

        // Starvation: one entry waiting, wb busy every cycle.
        cycle(0, 0, 0, 0, 0, 1, 8'h20, 32'hCAFE0020, acc);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 8'(8'h10 + i), 32'(i), 0, 0, 0, 0, acc);
            check_eq("starve_rw", 64'(rf_rw), (i == 4) ? 64'h20 : 64'(8'h10 + i));
        end

        // DEPTH=2, three back-to-back mem requests, wb continuously busy.
        e_rw[0] = 8'h31; e_d[0] = 32'hA0;
        e_rw[1] = 8'h32; e_d[1] = 32'hA1;
        e_rw[2] = 8'h33; e_d[2] = 32'hA2;
        k = 0;
        budget = 0;
        while (k < 3 && budget < 40) begin
            cycle(0, 1, 8'(8'h40 + budget), 32'(budget), 0, 1, e_rw[k], e_d[k], acc);
            if (acc) k++;
            if (k == 2 && acc) check_eq("full_ready", 64'(mem_ready), 64'd0);
            budget++;
        end
        check_eq("third_accepted", 64'(k), 64'd3);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Reset with two entries pending: flushed, never written.
        cycle(0, 1, 8'h50, 32'h50, 0, 1, 8'h61, 32'h61, acc);
        cycle(0, 1, 8'h51, 32'h51, 0, 1, 8'h62, 32'h62, acc);
        check_eq("pre_reset_pending", 64'(pending_count), 64'd2);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, acc);
        check_eq("post_reset_ready", 64'(mem_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Finished with one pending entry.
        cycle(0, 0, 0, 0, 1, 1, 8'h70, 32'h70, acc);
        check_eq("drained_pending", 64'(drained), 64'd0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, acc);
        check_eq("drained_inflight", 64'(drained), 64'd0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, acc);
        check_eq("drained_done", 64'(drained), 64'd1);

        // Random traffic; the memory requester holds its entry until taken.
        hold_v = 1'b0; hold_rw = '0; hold_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold_v && $urandom_range(0, 99) < 50) begin
                hold_v  = 1'b1;
                hold_rw = 8'($urandom);
                hold_d  = $urandom;
            end
            r_we  = ($urandom_range(0, 99) < 70);
            r_rw  = 8'($urandom);
            r_d   = $urandom;
            r_fin = ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 199) == 0), r_we, r_rw, r_d, r_fin,
                  hold_v, hold_rw, hold_d, acc);
            if (acc || reset) hold_v = 1'b0;
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0, acc);
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
